// File: rtl/comm_pkg.sv
// Shared types and helpers for the packet receiver.
package comm_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      TERM    = 1'b1
   } state_e;

   localparam int ERR_CNT_W = 16;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/comm_out_buf.sv
// Single-entry valid/ready holding register with overrun detection.
module comm_out_buf
   import comm_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic [W-1:0] data_o,
   output logic         valid_o,
   output logic         overrun_o
);

   logic [W-1:0] data_q;
   logic         valid_q;
   logic         ovr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= 1'b0;
         if (load_i) begin
            // a slot being drained this clock can take the new packet
            if (!valid_q || ready_i) begin
               data_q  <= data_i;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign overrun_o = ovr_q;

endmodule

// File: rtl/comm_packet_rx.sv
// Symbol-to-packet receiver: framing FSM, idle timeout, error counting.
module comm_packet_rx
   import comm_pkg::*;
#(
   parameter int IN_SIZE  = 6,
   parameter int OUT_SIZE = 32,
   parameter int TIMEOUT  = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sym_valid,
   input  logic [IN_SIZE-1:0]   sym,
   output logic [OUT_SIZE-1:0]  out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 timeout_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int SYMS = ceil_div(OUT_SIZE, IN_SIZE);
   localparam int SW   = SYMS * IN_SIZE;
   localparam int CW   = (SYMS > 1) ? $clog2(SYMS) : 1;
   localparam int IW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_e               state_q;
   logic [CW-1:0]        cnt_q;
   logic                 bad_q;
   logic [IW-1:0]        idle_q;
   logic [SW-1:0]        shift_q;
   logic [SW-1:0]        shift_d;
   logic                 frame_q;
   logic                 tmo_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic                 done;
   logic                 ovr;

   assign shift_d = (shift_q << IN_SIZE) | SW'(sym);

   assign done = (state_q == TERM) && sym_valid
               && (sym == '0) && !bad_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= COLLECT;
         cnt_q     <= '0;
         bad_q     <= 1'b0;
         idle_q    <= '0;
         shift_q   <= '0;
         frame_q   <= 1'b0;
         tmo_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         frame_q <= 1'b0;
         tmo_q   <= 1'b0;
         if ((frame_q || tmo_q || ovr) && (err_cnt_q != '1))
            err_cnt_q <= err_cnt_q + 1'b1;
         if (sym_valid) begin
            idle_q <= '0;
            unique case (state_q)
               COLLECT: begin
                  shift_q <= shift_d;
                  if (cnt_q == CW'(SYMS - 1)) begin
                     cnt_q   <= '0;
                     bad_q   <= 1'b0;
                     state_q <= TERM;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               TERM: begin
                  if (sym != '0) begin
                     bad_q <= 1'b1;
                  end else begin
                     state_q <= COLLECT;
                     cnt_q   <= '0;
                     frame_q <= bad_q;
                  end
               end
            endcase
         end else if (state_q == TERM || cnt_q != '0) begin
            // gap inside a packet; abort once it lasts TIMEOUT clocks
            if (TIMEOUT > 0 && idle_q == IW'(TIMEOUT - 1)) begin
               tmo_q   <= 1'b1;
               state_q <= COLLECT;
               cnt_q   <= '0;
               idle_q  <= '0;
            end else begin
               idle_q <= idle_q + 1'b1;
            end
         end
      end
   end

   comm_out_buf #(.W(OUT_SIZE)) u_buf (
      .clk       (clk),
      .reset     (reset),
      .load_i    (done),
      .data_i    (shift_q[OUT_SIZE-1:0]),
      .ready_i   (out_ready),
      .data_o    (out_data),
      .valid_o   (out_valid),
      .overrun_o (ovr)
   );

   assign overrun     = ovr;
   assign frame_err   = frame_q;
   assign timeout_err = tmo_q;
   assign err_count   = err_cnt_q;

endmodule

// File: doc/comm_packet_rx.md
COMM_PACKET_RX -- requirements
Module: comm_packet_rx

Interface
REQ-001 Parameter IN_SIZE, default 6: symbol width in bits.
REQ-002 Parameter OUT_SIZE, default 32: packet payload width in bits.
REQ-003 Parameter TIMEOUT, default 255: maximum idle clocks between symbols inside a packet; 0 disables the timeout.
REQ-004 Derived constant SYMS = ceil(OUT_SIZE/IN_SIZE), which is 6 at the defaults.
REQ-005 Port clk  in  1: the single clock; all logic on posedge.
REQ-006 Port reset  in  1: synchronous, active-high reset.
REQ-007 Port sym_valid  in  1: qualifies sym for one clock.
REQ-008 Port sym  in  IN_SIZE: input symbol.
REQ-009 Port out_data  out  OUT_SIZE: received payload.
REQ-010 Port out_valid  out  1: out_data is held and valid.
REQ-011 Port out_ready  in  1: consumer accepts; transfer occurs when out_valid && out_ready.
REQ-012 Port frame_err  out  1: one-clock pulse on a packet dropped for a bad terminator.
REQ-013 Port overrun  out  1: one-clock pulse on a good packet dropped because the output buffer is full.
REQ-014 Port timeout_err  out  1: one-clock pulse on a packet aborted by an idle gap.
REQ-015 Port err_count  out  16: saturating total of frame, overrun and timeout events.

Function
REQ-016 Framing: packet = SYMS data symbols, MSB-first, followed by terminator symbols; only cycles with sym_valid=1 are counted.
REQ-017 Assembly: shift = (shift << IN_SIZE) | sym; out payload = low OUT_SIZE bits of the SYMS*IN_SIZE-bit shift; excess upper bits are discarded.
REQ-018 State COLLECT: counts data symbols 0..SYMS-1; after the SYMS-th symbol, next state is TERM with bad cleared.
REQ-019 State TERM, sym != 0: sets bad; stays in TERM.
REQ-020 State TERM, sym == 0, bad=0: packet complete; next state is COLLECT with count 0.
REQ-021 State TERM, sym == 0, bad=1: frame_err pulse, packet discarded; next state is COLLECT.
REQ-022 Completion into an empty buffer, or into a full buffer being drained in the same clock (out_ready=1): load out_data and set out_valid the next clock; no overrun. Latency: terminator edge to out_valid = 1 clock.
REQ-023 Completion into a full buffer with out_ready=0: overrun pulse, new packet dropped, held data unchanged.
REQ-024 out_data is stable while out_valid=1 && out_ready=0; out_valid clears the clock after a transfer unless it is reloaded that same clock.
REQ-025 Idle counter: counts clocks with sym_valid=0 while in TERM, or in COLLECT with count>0; clears on sym_valid.
REQ-026 When the idle counter reaches TIMEOUT (TIMEOUT>0): timeout_err pulse, return to COLLECT with count 0; the partial packet is discarded.
REQ-027 At most one error pulse per clock; frame_err, overrun and timeout_err are mutually exclusive by construction.
REQ-028 err_count increments by 1 per error pulse and saturates at 0xFFFF.

Reset
REQ-029 While reset=1 on a clock edge, set: state=COLLECT, count=0, bad=0, idle counter=0, shift=0, out_data=0, out_valid=0, all error pulses=0, err_count=0.
REQ-030 Reset mid-packet or mid-hold discards all data; the first valid symbol after reset deasserts is data symbol 0.
REQ-031 All outputs are 0 out of power-up initialisation.

Structure
REQ-032 Package comm_pkg holds the state encoding (COLLECT, TERM), the SYMS ceil function and the ERR_CNT_W=16 constant.
REQ-033 One sub-module, comm_out_buf, implements the single-entry valid/ready holding register and overrun detection; the framing FSM stays in comm_packet_rx.

Verification
REQ-034 Defaults; symbols 01,02,03,04,05,06 then 00 -> out_valid one clock later, out_data=0x420C4146, no error.
REQ-035 Same packet, but the terminator phase is 07,00 -> frame_err pulse, err_count=1, out_valid stays 0.
REQ-036 Two good packets back-to-back with out_ready=0 -> first is held, overrun pulse on the second, out_data unchanged; repeat with out_ready=1 on the second terminator clock -> no overrun, second data loaded.
REQ-037 TIMEOUT=4; three data symbols, then sym_valid=0 for 4 clocks -> timeout_err pulse; the following full packet is received correctly.
REQ-038 reset asserted after three symbols and while out_valid=1 -> all outputs 0; next packet 3F x6, 00 -> out_data=0xFFFFFFFF.
REQ-039 Force err_count=0xFFFE, then three frame errors -> saturates at 0xFFFF.
